// File: rtl/apb_cmd_queue.sv
// Command FIFO feeding apb_master: queues host requests, issues them one at a time,
// aborts hung transfers on timeout and counts completed transfers.
module apb_cmd_queue #(
   parameter int DEPTH   = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_wr,
   input  logic [ADDR_W-1:0]        cmd_addr,
   input  logic [DATA_W-1:0]        cmd_data,
   output logic                     mst_sel,
   output logic                     mst_wr,
   output logic [ADDR_W-1:0]        mst_addr,
   output logic [DATA_W-1:0]        mst_data,
   input  logic                     mst_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     timeout_err,
   input  logic                     err_clr,
   output logic [15:0]              done_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int WW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } cmd_t;

   cmd_t          mem [DEPTH];
   cmd_t          head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] count;
   logic [WW-1:0] wait_cnt;
   state_t        state;
   logic          push;
   logic          pop;
   logic          expire;

   assign cmd_ready = (count != LW'(DEPTH)) && !rst;
   assign push      = cmd_valid && cmd_ready;
   assign expire    = (wait_cnt == WW'(TIMEOUT - 1));
   // The head leaves the FIFO only when its transfer ends, either way.
   assign pop       = (state == ISSUE) && (mst_ready || expire);
   assign head      = mem[rd_ptr];
   assign level     = count;

   // NOTE: storage is not reset; an entry is only read after count says it was written.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cmd_wr, cmd_addr, cmd_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         mst_sel     <= 1'b0;
         mst_wr      <= 1'b0;
         mst_addr    <= '0;
         mst_data    <= '0;
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
         done_cnt    <= '0;
      end else begin
         // Clear first so a timeout at the same edge overrides it.
         if (err_clr) timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (count != '0) begin
                  state    <= ISSUE;
                  mst_sel  <= 1'b1;
                  mst_wr   <= head.wr;
                  mst_addr <= head.addr;
                  mst_data <= head.data;
                  wait_cnt <= '0;
               end
            end
            ISSUE: begin
               if (mst_ready) begin
                  done_cnt <= done_cnt + 16'd1;
                  mst_sel  <= 1'b0;
                  state    <= GAP;
               end else if (expire) begin
                  timeout_err <= 1'b1;
                  mst_sel     <= 1'b0;
                  state       <= GAP;
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end
            GAP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cmd_queue.sv
// Directed bench for apb_cmd_queue: inputs driven and outputs checked on the falling edge.
module tb_apb_cmd_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_wr;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_data;
   logic        mst_sel;
   logic        mst_wr;
   logic [7:0]  mst_addr;
   logic [31:0] mst_data;
   logic        mst_ready;
   logic [2:0]  level;
   logic        timeout_err;
   logic        err_clr;
   logic [15:0] done_cnt;

   int checks = 0;
   int errors = 0;

   apb_cmd_queue #(.DEPTH(4), .ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .mst_sel(mst_sel), .mst_wr(mst_wr), .mst_addr(mst_addr), .mst_data(mst_data),
      .mst_ready(mst_ready), .level(level), .timeout_err(timeout_err),
      .err_clr(err_clr), .done_cnt(done_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push_one(input logic wr, input logic [7:0] addr, input logic [31:0] data);
      cmd_valid = 1'b1;
      cmd_wr    = wr;
      cmd_addr  = addr;
      cmd_data  = data;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_data = '0;
      mst_ready = 1'b0; err_clr = 1'b0;
      tick(); tick();
      check("rst_ready",  cmd_ready, 0);
      check("rst_sel",    mst_sel, 0);
      check("rst_level",  level, 0);
      check("rst_done",   done_cnt, 0);
      check("rst_err",    timeout_err, 0);
      rst = 1'b0;
      tick();

      // Single write, completed on the third ISSUE cycle
      push_one(1'b1, 8'h12, 32'hDEADBEEF);
      check("w_level",    level, 1);
      check("w_sel_idle", mst_sel, 0);
      tick();
      check("w_sel",      mst_sel, 1);
      check("w_wr",       mst_wr, 1);
      check("w_addr",     mst_addr, 8'h12);
      check("w_data",     mst_data, 32'hDEADBEEF);
      tick();
      check("w_hold_addr", mst_addr, 8'h12);
      check("w_hold_data", mst_data, 32'hDEADBEEF);
      mst_ready = 1'b1;
      tick();
      mst_ready = 1'b0;
      check("w_sel_off",  mst_sel, 0);
      check("w_done",     done_cnt, 1);
      check("w_level0",   level, 0);
      tick();

      // Fill to full; a fifth request must be refused
      for (int i = 0; i < 4; i++) push_one(1'b1, 8'(8'h20 + i), 32'(i));
      check("full_ready", cmd_ready, 0);
      check("full_level", level, 4);
      cmd_valid = 1'b1; cmd_addr = 8'h55;
      tick();
      check("full_level_hold", level, 4);
      mst_ready = 1'b1;
      tick();
      mst_ready = 1'b0;
      cmd_valid = 1'b0;
      check("pop_ready",  cmd_ready, 1);
      check("pop_level",  level, 3);
      check("pop_done",   done_cnt, 2);
      mst_ready = 1'b1;
      for (int i = 0; i < 20 && level != 0; i++) tick();
      mst_ready = 1'b0;
      check("drain_level", level, 0);
      check("drain_done",  done_cnt, 5);
      tick();

      // Read that never completes must time out after 16 ISSUE cycles
      push_one(1'b0, 8'h34, 32'h0);
      tick();
      check("to_sel",     mst_sel, 1);
      check("to_wr",      mst_wr, 0);
      for (int i = 0; i < 15; i++) tick();
      check("to_sel16",   mst_sel, 1);
      tick();
      check("to_sel_off", mst_sel, 0);
      check("to_err",     timeout_err, 1);
      check("to_done",    done_cnt, 5);
      check("to_level",   level, 0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("to_clr",     timeout_err, 0);

      // Completion on the 16th ISSUE cycle beats the timeout
      push_one(1'b1, 8'h56, 32'h1);
      tick();
      for (int i = 0; i < 15; i++) tick();
      mst_ready = 1'b1;
      tick();
      mst_ready = 1'b0;
      check("last_sel",   mst_sel, 0);
      check("last_err",   timeout_err, 0);
      check("last_done",  done_cnt, 6);
      tick();

      // Push and pop on the same edge, order preserved
      push_one(1'b1, 8'h01, 32'h0);
      push_one(1'b1, 8'h02, 32'h0);
      check("ord_addr1",  mst_addr, 8'h01);
      check("ord_level",  level, 2);
      cmd_valid = 1'b1; cmd_addr = 8'h03; mst_ready = 1'b1;
      tick();
      cmd_valid = 1'b0; mst_ready = 1'b0;
      check("ord_level_same", level, 2);
      tick(); tick();
      check("ord_sel2",   mst_sel, 1);
      check("ord_addr2",  mst_addr, 8'h02);
      mst_ready = 1'b1;
      tick();
      mst_ready = 1'b0;
      tick(); tick();
      check("ord_addr3",  mst_addr, 8'h03);
      mst_ready = 1'b1;
      tick();
      mst_ready = 1'b0;
      check("ord_level0", level, 0);
      check("ord_done",   done_cnt, 9);
      tick();

      // Reset in the middle of a transfer with three queued
      for (int i = 0; i < 3; i++) push_one(1'b1, 8'(8'h40 + i), 32'(i));
      check("mr_sel",     mst_sel, 1);
      check("mr_level",   level, 3);
      rst = 1'b1;
      tick();
      check("mr_sel_off", mst_sel, 0);
      check("mr_level0",  level, 0);
      check("mr_done",    done_cnt, 0);
      check("mr_ready_rst", cmd_ready, 0);
      rst = 1'b0;
      tick();
      check("mr_ready",   cmd_ready, 1);
      check("mr_sel_idle", mst_sel, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
